// File: rtl/axi4_refill_resp_serializer.sv
// Refill response serializer: one cache line in, AXI4 R burst out.
// Optional macro REFILL_RESP_SER_PERF_CNT_EN adds burst/stall counters.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   line_*_i          wide line request (id/data/resp/user/single/valid)
//   line_ready_o      line accepted when valid & ready
//   init_r*_o         AXI4 R channel (rid/rdata/rresp/rlast/ruser/rvalid)
//   init_rready_i     AXI4 RREADY
//   perf_lines_o      completed bursts, saturating (macro only)
//   perf_stall_o      rvalid & !rready cycles, saturating (macro only)
module axi4_refill_resp_serializer #(
  parameter int CACHE_LINE        = 4,
  parameter int ICACHE_DATA_WIDTH = 32,
  parameter int AXI_ID            = 6,
  parameter int AXI_DATA          = 64,
  parameter int AXI_USER          = 8
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [AXI_ID-1:0]                       line_id_i,
  input  logic [CACHE_LINE*ICACHE_DATA_WIDTH-1:0] line_data_i,
  input  logic [1:0]                              line_resp_i,
  input  logic [AXI_USER-1:0]                     line_user_i,
  input  logic                                    line_single_i,
  input  logic                                    line_valid_i,
  output logic                                    line_ready_o,
  output logic [AXI_ID-1:0]                       init_rid_o,
  output logic [AXI_DATA-1:0]                     init_rdata_o,
  output logic [1:0]                              init_rresp_o,
  output logic                                    init_rlast_o,
  output logic [AXI_USER-1:0]                     init_ruser_o,
  output logic                                    init_rvalid_o,
  input  logic                                    init_rready_i
`ifdef REFILL_RESP_SER_PERF_CNT_EN
  ,
  output logic [31:0]                             perf_lines_o,
  output logic [31:0]                             perf_stall_o
`endif
);

  localparam int LW = CACHE_LINE * ICACHE_DATA_WIDTH;
  localparam int NB = LW / AXI_DATA;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]                r_cnt;
  logic [CW-1:0]                w_cnt_nxt;
  logic [NB-1:0][AXI_DATA-1:0]  r_line;
  logic [AXI_ID-1:0]            r_id;
  logic [1:0]                   r_resp;
  logic [AXI_USER-1:0]          r_user;
  logic                         r_single;

  logic w_send;
  logic w_last;
  logic w_hs;
  logic w_ready;
  logic w_load;

  assign w_send = (r_state == SEND);
  assign w_last = w_send & ((r_cnt == LAST_CNT) | r_single);
  assign w_hs   = w_send & init_rready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A last-beat handshake may take the next line in the same cycle,
  // so back-to-back lines stream without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_ready = 1'b1;
        if (line_valid_i) begin
          w_load      = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        w_ready = init_rready_i & w_last;
        if (w_hs) begin
          if (w_last) begin
            w_cnt_nxt = '0;
            if (line_valid_i) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line   <= '0;
      r_id     <= '0;
      r_resp   <= '0;
      r_user   <= '0;
      r_single <= 1'b0;
    end else if (w_load) begin
      r_line   <= line_data_i;
      r_id     <= line_id_i;
      r_resp   <= line_resp_i;
      r_user   <= line_user_i;
      r_single <= line_single_i;
    end
  end

  // Outputs are forced quiet for the whole time rst is high,
  // including before the first reset edge.
  assign line_ready_o  = w_ready & ~rst;
  assign init_rvalid_o = w_send & ~rst;
  assign init_rlast_o  = w_last & ~rst;
  assign init_rdata_o  = rst ? '0 : r_line[r_cnt];
  assign init_rid_o    = rst ? '0 : r_id;
  assign init_rresp_o  = rst ? '0 : r_resp;
  assign init_ruser_o  = rst ? '0 : r_user;

`ifdef REFILL_RESP_SER_PERF_CNT_EN
  logic [31:0] r_perf_lines;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_lines <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_hs & w_last & ~&r_perf_lines) begin
        r_perf_lines <= r_perf_lines + 32'd1;
      end
      if (w_send & ~init_rready_i & ~&r_perf_stall) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_lines_o = r_perf_lines;
  assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_axi4_refill_resp_serializer.sv
// Bench for axi4_refill_resp_serializer: directed steps plus random
// traffic against a queue-of-beats reference model.
module tb_axi4_refill_resp_serializer;

  localparam int NB = 2;

  logic         clk;
  logic         rst;
  logic [5:0]   line_id_i;
  logic [127:0] line_data_i;
  logic [1:0]   line_resp_i;
  logic [7:0]   line_user_i;
  logic         line_single_i;
  logic         line_valid_i;
  logic         line_ready_o;
  logic [5:0]   init_rid_o;
  logic [63:0]  init_rdata_o;
  logic [1:0]   init_rresp_o;
  logic         init_rlast_o;
  logic [7:0]   init_ruser_o;
  logic         init_rvalid_o;
  logic         init_rready_i;
`ifdef REFILL_RESP_SER_PERF_CNT_EN
  logic [31:0]  perf_lines_o;
  logic [31:0]  perf_stall_o;
`endif

  axi4_refill_resp_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .line_id_i    (line_id_i),
    .line_data_i  (line_data_i),
    .line_resp_i  (line_resp_i),
    .line_user_i  (line_user_i),
    .line_single_i(line_single_i),
    .line_valid_i (line_valid_i),
    .line_ready_o (line_ready_o),
    .init_rid_o   (init_rid_o),
    .init_rdata_o (init_rdata_o),
    .init_rresp_o (init_rresp_o),
    .init_rlast_o (init_rlast_o),
    .init_ruser_o (init_ruser_o),
    .init_rvalid_o(init_rvalid_o),
    .init_rready_i(init_rready_i)
`ifdef REFILL_RESP_SER_PERF_CNT_EN
    ,
    .perf_lines_o (perf_lines_o),
    .perf_stall_o (perf_stall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic [7:0]  user;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    checks;
  int    errors;
  int    m_lines;
  int    m_stall;

  localparam logic [127:0] LINE_A =
    128'h4444_4444_3333_3333_2222_2222_1111_1111;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input logic [127:0] d,
                           input logic [5:0] id,
                           input logic [1:0] rs,
                           input logic [7:0] us,
                           input logic s);
    beat_t b;
    for (int k = 0; k < NB; k++) begin
      b.id   = id;
      b.data = d[k*64 +: 64];
      b.resp = rs;
      b.user = us;
      b.last = (k == NB - 1) || s;
      exp_q.push_back(b);
      if (s) break;
    end
  endtask

  task automatic cyc(input logic v, input logic s, input logic rr,
                     input logic [127:0] d, input logic [5:0] id,
                     input logic [1:0] rs, input logic [7:0] us);
    logic exp_ready;
    int   n;
    rst           = 1'b0;
    line_valid_i  = v;
    line_single_i = s;
    line_data_i   = d;
    line_id_i     = id;
    line_resp_i   = rs;
    line_user_i   = us;
    init_rready_i = rr;
    #2;
    n = exp_q.size();
    exp_ready = (n == 0) || (rr && n == 1);
    chk("rvalid", 128'(init_rvalid_o), 128'(n != 0));
    chk("line_ready", 128'(line_ready_o), 128'(exp_ready));
    if (n != 0) begin
      chk("rid", 128'(init_rid_o), 128'(exp_q[0].id));
      chk("rdata", 128'(init_rdata_o), 128'(exp_q[0].data));
      chk("rresp", 128'(init_rresp_o), 128'(exp_q[0].resp));
      chk("ruser", 128'(init_ruser_o), 128'(exp_q[0].user));
      chk("rlast", 128'(init_rlast_o), 128'(exp_q[0].last));
    end
    @(posedge clk);
    if (n != 0) begin
      if (rr) begin
        if (exp_q[0].last) m_lines++;
        void'(exp_q.pop_front());
      end else begin
        m_stall++;
      end
    end
    if (v && exp_ready) push_line(d, id, rs, us, s);
    #1;
  endtask

  task automatic idle(input logic rr);
    cyc(1'b0, 1'b0, rr, '0, '0, '0, '0);
  endtask

  task automatic rst_cyc();
    rst           = 1'b1;
    line_valid_i  = 1'($urandom_range(0, 1));
    init_rready_i = 1'($urandom_range(0, 1));
    #2;
    chk("rst_rvalid", 128'(init_rvalid_o), 128'(0));
    chk("rst_rlast", 128'(init_rlast_o), 128'(0));
    chk("rst_rresp", 128'(init_rresp_o), 128'(0));
    chk("rst_rid", 128'(init_rid_o), 128'(0));
    chk("rst_ruser", 128'(init_ruser_o), 128'(0));
    chk("rst_rdata", 128'(init_rdata_o), 128'(0));
    chk("rst_lready", 128'(line_ready_o), 128'(0));
    @(posedge clk);
    exp_q.delete();
    m_lines = 0;
    m_stall = 0;
    #1;
  endtask

  task automatic chk_perf();
`ifdef REFILL_RESP_SER_PERF_CNT_EN
    chk("perf_lines", 128'(perf_lines_o), 128'(m_lines));
    chk("perf_stall", 128'(perf_stall_o), 128'(m_stall));
`endif
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] d2;
    checks        = 0;
    errors        = 0;
    m_lines       = 0;
    m_stall       = 0;
    rst           = 1'b1;
    line_valid_i  = 1'b0;
    line_single_i = 1'b0;
    line_data_i   = '0;
    line_id_i     = '0;
    line_resp_i   = '0;
    line_user_i   = '0;
    init_rready_i = 1'b0;

    rst_cyc();
    rst_cyc();
    idle(1'b1);
    chk_perf();

    // basic two-beat burst
    cyc(1'b1, 1'b0, 1'b1, LINE_A, 6'h15, 2'b00, 8'h00);
    chk("t1_b0_data", 128'(init_rdata_o), 128'(64'h2222_2222_1111_1111));
    chk("t1_b0_last", 128'(init_rlast_o), 128'(0));
    chk("t1_b0_rid", 128'(init_rid_o), 128'(6'h15));
    idle(1'b1);
    chk("t1_b1_data", 128'(init_rdata_o), 128'(64'h4444_4444_3333_3333));
    chk("t1_b1_last", 128'(init_rlast_o), 128'(1));
    idle(1'b1);
    idle(1'b1);

    // single-beat fetch
    cyc(1'b1, 1'b1, 1'b1, LINE_A, 6'h15, 2'b00, 8'h00);
    chk("t2_data", 128'(init_rdata_o), 128'(64'h2222_2222_1111_1111));
    chk("t2_last", 128'(init_rlast_o), 128'(1));
    idle(1'b1);
    idle(1'b1);
    chk_perf();

    // stall beat 1 for five cycles
    cyc(1'b1, 1'b0, 1'b1, LINE_A, 6'h2a, 2'b01, 8'h3c);
    idle(1'b1);
    for (int i = 0; i < 5; i++) idle(1'b0);
    idle(1'b1);
    idle(1'b1);
`ifdef REFILL_RESP_SER_PERF_CNT_EN
    chk("t3_stall5", 128'(perf_stall_o), 128'(5));
`endif
    chk_perf();

    // back-to-back lines, valid held high
    d  = {$urandom, $urandom, $urandom, $urandom};
    d2 = {$urandom, $urandom, $urandom, $urandom};
    cyc(1'b1, 1'b0, 1'b1, d, 6'h01, 2'b00, 8'h11);
    cyc(1'b1, 1'b0, 1'b1, d2, 6'h02, 2'b00, 8'h22);
    cyc(1'b1, 1'b0, 1'b1, d2, 6'h02, 2'b00, 8'h22);
    chk("t4_nobubble", 128'(init_rvalid_o), 128'(1));
    chk("t4_l2_data", 128'(init_rdata_o), 128'(d2[63:0]));
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // reset mid-burst
    cyc(1'b1, 1'b0, 1'b1, d, 6'h07, 2'b00, 8'h00);
    idle(1'b1);
    rst_cyc();
    idle(1'b1);
    cyc(1'b1, 1'b0, 1'b1, d2, 6'h08, 2'b00, 8'h00);
    chk("t5_restart_b0", 128'(init_rdata_o), 128'(d2[63:0]));
    idle(1'b1);
    idle(1'b1);

    // resp / user propagated to every beat
    d = {$urandom, $urandom, $urandom, $urandom};
    cyc(1'b1, 1'b0, 1'b1, d, 6'h33, 2'b10, 8'ha5);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk_perf();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      cyc(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 9) < 7),
          d,
          6'($urandom_range(0, 63)),
          2'($urandom_range(0, 3)),
          8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("drain", 128'(exp_q.size()), 128'(0));
    chk_perf();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
